prio_encoder_reg: RTL and testbench

// - Parametrised, registered successor to the team's 8-to-3 one-hot encoder.
// - Encodes an N_IN-bit request vector to a binary index with defined priority.

---
 rtl/prio_encoder_reg.sv | 106 ++++++++++
 tb/tb_prio_encoder_reg.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_reg.sv
// rtl/prio_encoder_reg.sv - registered N_IN-to-index priority encoder with valid/ready output; ROUND_ROBIN_EN selects rotating priority
module prio_encoder_reg #(
  parameter int N_IN      = 8,
  parameter int OUT_W     = 3,
  parameter int MSB_FIRST = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_W-1:0]     out_idx,
  output logic                 out_zero,
  output logic                 out_multi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Reject configurations whose index width cannot address exactly N_IN lines
  generate
    if (N_IN < 2 || OUT_W != $clog2(N_IN)) begin : g_bad_cfg
      $error("prio_encoder_reg: need N_IN >= 2 and OUT_W == $clog2(N_IN)");
    end
  endgenerate

  logic             accept;
  logic [OUT_W-1:0] enc_idx;
  logic             enc_zero;
  logic             enc_multi;

  // The output register frees up when empty or being drained this cycle
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef ROUND_ROBIN_EN
  logic [OUT_W-1:0] ptr;

  // Rotating search starting at ptr; scanning farthest-first lets the nearest set bit win
  always_comb begin
    int j;
    enc_idx   = '0;
    j         = 0;
    enc_zero  = (in_vec == '0);
    enc_multi = |(in_vec & (in_vec - N_IN'(1)));
    for (int k = N_IN - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_IN) j = j - N_IN;
      if (in_vec[OUT_W'(j)]) enc_idx = OUT_W'(j);
    end
  end

  // Pointer moves just past the granted line; all-zero vectors grant nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && !enc_zero) begin
      ptr <= (enc_idx == OUT_W'(N_IN - 1)) ? '0 : enc_idx + 1'b1;
    end
  end
`else
  // Fixed priority; the last assignment in scan order is the winning bit
  always_comb begin
    enc_idx   = '0;
    enc_zero  = (in_vec == '0);
    enc_multi = |(in_vec & (in_vec - N_IN'(1)));
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_vec[OUT_W'(i)]) enc_idx = OUT_W'(i);
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (in_vec[OUT_W'(i)]) enc_idx = OUT_W'(i);
      end
    end
  end
`endif

  // Single-entry result register: load on accept, otherwise clear valid when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx   <= '0;
      out_zero  <= 1'b0;
      out_multi <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_idx   <= enc_idx;
      out_zero  <= enc_zero;
      out_multi <= enc_multi;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of accepted multi-hot vectors; never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && enc_multi && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_prio_encoder_reg.sv
// tb/tb_prio_encoder_reg.sv - randomized self-checking bench for prio_encoder_reg
module tb_prio_encoder_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_vec = '0;
  logic [5:0] vec6 = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       rdy[3];
  logic [2:0] o_idx[3];
  logic       o_zero[3];
  logic       o_multi[3];
  logic       o_valid[3];
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;

  int checks = 0;
  int fails = 0;

  int m_valid[3], m_idx[3], m_zero[3], m_multi[3], m_cnt[3], m_ptr[3];
  int n_of[3]   = '{8, 8, 6};
  int msb_of[3] = '{0, 1, 0};
  int max_of[3] = '{255, 3, 255};

  always #5 clk = ~clk;

  prio_encoder_reg #(.N_IN(8), .OUT_W(3), .MSB_FIRST(0), .ERR_CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(rdy[0]),
    .out_idx(o_idx[0]), .out_zero(o_zero[0]), .out_multi(o_multi[0]),
    .out_valid(o_valid[0]), .out_ready(out_ready), .err_cnt(cnt0));

  prio_encoder_reg #(.N_IN(8), .OUT_W(3), .MSB_FIRST(1), .ERR_CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(rdy[1]),
    .out_idx(o_idx[1]), .out_zero(o_zero[1]), .out_multi(o_multi[1]),
    .out_valid(o_valid[1]), .out_ready(out_ready), .err_cnt(cnt1));

  prio_encoder_reg #(.N_IN(6), .OUT_W(3), .MSB_FIRST(0), .ERR_CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_vec(vec6), .in_valid(in_valid), .in_ready(rdy[2]),
    .out_idx(o_idx[2]), .out_zero(o_zero[2]), .out_multi(o_multi[2]),
    .out_valid(o_valid[2]), .out_ready(out_ready), .err_cnt(cnt2));

  function automatic int cnt_of(int i);
    if (i == 0) return int'(cnt0);
    if (i == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  function automatic int vec_of(int i);
    if (i == 2) return int'(vec6);
    return int'(in_vec);
  endfunction

  // Walk the lines in priority order; the first set one is granted
  function automatic int ref_idx(int vec, int n, int msb, int p);
    int pos;
    for (int k = 0; k < n; k++) begin
`ifdef ROUND_ROBIN_EN
      pos = (p + k) % n;
`else
      pos = (msb != 0) ? (n - 1 - k) : k;
`endif
      if (((vec >> pos) & 1) != 0) return pos;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0; m_idx[i] = 0; m_zero[i] = 0;
      m_multi[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
    end
  endtask

  // Advance one clock and update the reference model; no comparisons here
  task automatic tick();
    int acc[3];
    int v[3];
    #1;
    for (int i = 0; i < 3; i++) begin
      acc[i] = (in_valid && (m_valid[i] == 0 || out_ready)) ? 1 : 0;
      v[i] = vec_of(i);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (acc[i] != 0) begin
        m_valid[i] = 1;
        m_idx[i]   = ref_idx(v[i], n_of[i], msb_of[i], m_ptr[i]);
        m_zero[i]  = (v[i] == 0) ? 1 : 0;
        m_multi[i] = ($countones(v[i]) > 1) ? 1 : 0;
        if (m_multi[i] != 0 && m_cnt[i] < max_of[i]) m_cnt[i]++;
        if (v[i] != 0) m_ptr[i] = (m_idx[i] + 1) % n_of[i];
      end else if (out_ready) begin
        m_valid[i] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid[i] !== 1'b0 || o_idx[i] !== 3'd0 || o_zero[i] !== 1'b0 ||
          o_multi[i] !== 1'b0 || cnt_of(i) != 0 || rdy[i] !== 1'b1) begin
        fails++;
        $display("FAIL reset_state dut%0d got valid=%b idx=%0d zero=%b multi=%b cnt=%0d rdy=%b exp all 0, rdy=1",
                 i, o_valid[i], o_idx[i], o_zero[i], o_multi[i], cnt_of(i), rdy[i]);
      end
    end
    in_vec = 8'hC0; vec6 = 6'h30; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid[i] !== 1'b1) begin
        fails++;
        $display("FAIL pre_reset_valid dut%0d got=%b exp=1", i, o_valid[i]);
      end
    end
    #2;
    rst = 1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid[i] !== 1'b0 || o_idx[i] !== 3'd0 || o_zero[i] !== 1'b0 ||
          o_multi[i] !== 1'b0 || cnt_of(i) != 0) begin
        fails++;
        $display("FAIL async_reset dut%0d got valid=%b idx=%0d zero=%b multi=%b cnt=%0d exp all 0",
                 i, o_valid[i], o_idx[i], o_zero[i], o_multi[i], cnt_of(i));
      end
    end
    @(negedge clk);
    rst = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b1) begin
        fails++;
        $display("FAIL ready_after_reset dut%0d got=%b exp=1", i, rdy[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_onehot();
    for (int k = 0; k < 8; k++) begin
      in_vec = 8'(1 << k); vec6 = 6'(1 << (k % 6)); in_valid = 1; out_ready = 1;
      tick();
      checks++;
      if (o_idx[0] !== 3'(k) || o_zero[0] !== 1'b0 || o_multi[0] !== 1'b0 || o_valid[0] !== 1'b1) begin
        fails++;
        $display("FAIL onehot k=%0d got idx=%0d zero=%b multi=%b valid=%b exp idx=%0d 0 0 1",
                 k, o_idx[0], o_zero[0], o_multi[0], o_valid[0], k);
      end
      checks++;
      if (int'(o_idx[2]) != (k % 6) || int'(o_idx[1]) != k) begin
        fails++;
        $display("FAIL onehot_other k=%0d got idx1=%0d idx2=%0d exp %0d %0d", k, o_idx[1], o_idx[2], k, k % 6);
      end
    end
  endtask

  task automatic test_multi();
    int prev0;
    prev0 = m_cnt[0];
    in_vec = 8'b1010_0100; vec6 = 6'b000011; in_valid = 1; out_ready = 1;
    tick();
`ifndef ROUND_ROBIN_EN
    checks++;
    if (o_idx[0] !== 3'd2 || o_idx[1] !== 3'd7) begin
      fails++;
      $display("FAIL multi_fixed got idx0=%0d idx1=%0d exp 2 7", o_idx[0], o_idx[1]);
    end
`endif
    checks++;
    if (o_multi[0] !== 1'b1 || o_multi[1] !== 1'b1 || o_multi[2] !== 1'b1) begin
      fails++;
      $display("FAIL multi_flag got %b%b%b exp 111", o_multi[0], o_multi[1], o_multi[2]);
    end
    checks++;
    if (cnt_of(0) != prev0 + 1) begin
      fails++;
      $display("FAIL multi_errcnt got=%0d exp=%0d", cnt_of(0), prev0 + 1);
    end
  endtask

  task automatic test_backpressure();
    int held;
    in_valid = 0; out_ready = 1;
    tick();
    in_vec = 8'h10; vec6 = 6'h04; in_valid = 1; out_ready = 1;
    tick();
    held = ref_idx(8'h10, 8, 0, 0);
    in_vec = 8'h02; vec6 = 6'h02; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rdy[0] !== 1'b0) begin
        fails++;
        $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, rdy[0]);
      end
      tick();
      checks++;
      if (int'(o_idx[0]) != held || o_valid[0] !== 1'b1) begin
        fails++;
        $display("FAIL bp_frozen cycle=%0d got idx=%0d valid=%b exp idx=%0d valid=1", c, o_idx[0], o_valid[0], held);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready got=%b exp=1", rdy[0]);
    end
    tick();
    in_valid = 0; out_ready = 0;
    checks++;
    if (o_idx[0] !== 3'd1 || o_valid[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_next got idx=%0d valid=%b exp idx=1 valid=1", o_idx[0], o_valid[0]);
    end
  endtask

  task automatic test_zero_sat();
    int prev[3];
    for (int i = 0; i < 3; i++) prev[i] = m_cnt[i];
    in_vec = 8'h00; vec6 = 6'h00; in_valid = 1; out_ready = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_zero[i] !== 1'b1 || o_idx[i] !== 3'd0 || o_valid[i] !== 1'b1 || cnt_of(i) != prev[i]) begin
        fails++;
        $display("FAIL zero_input dut%0d got zero=%b idx=%0d valid=%b cnt=%0d exp 1 0 1 cnt=%0d",
                 i, o_zero[i], o_idx[i], o_valid[i], cnt_of(i), prev[i]);
      end
    end
    for (int r = 0; r < 5; r++) begin
      in_vec = 8'hC3; vec6 = 6'h21;
      tick();
    end
    checks++;
    if (cnt1 !== 2'd3) begin
      fails++;
      $display("FAIL errcnt_saturate got=%0d exp=3", cnt1);
    end
    checks++;
    if (cnt_of(0) != m_cnt[0]) begin
      fails++;
      $display("FAIL errcnt_count got=%0d exp=%0d", cnt_of(0), m_cnt[0]);
    end
    in_valid = 0;
  endtask

`ifdef ROUND_ROBIN_EN
  task automatic test_round_robin();
    do_reset();
    in_valid = 1; out_ready = 1;
    for (int r = 0; r < 5; r++) begin
      in_vec = 8'hFF; vec6 = 6'h3F;
      tick();
      checks++;
      if (int'(o_idx[0]) != r || int'(o_idx[2]) != r) begin
        fails++;
        $display("FAIL rr_sweep r=%0d got idx0=%0d idx2=%0d exp %0d", r, o_idx[0], o_idx[2], r);
      end
    end
    in_vec = 8'h01; vec6 = 6'b100001;
    tick();
    checks++;
    if (o_idx[0] !== 3'd0 || o_idx[2] !== 3'd5) begin
      fails++;
      $display("FAIL rr_wrap got idx0=%0d idx2=%0d exp 0 5", o_idx[0], o_idx[2]);
    end
    in_vec = 8'hFF; vec6 = 6'h3F;
    tick();
    checks++;
    if (o_idx[0] !== 3'd1 || o_idx[2] !== 3'd0) begin
      fails++;
      $display("FAIL rr_pointer got idx0=%0d idx2=%0d exp 1 0", o_idx[0], o_idx[2]);
    end
    in_valid = 0;
  endtask
`endif

  task automatic test_random();
    int mode;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        in_vec = 8'h00; vec6 = 6'h00;
      end else if (mode == 1) begin
        in_vec = 8'(1 << $urandom_range(0, 7)); vec6 = 6'(1 << $urandom_range(0, 5));
      end else begin
        in_vec = 8'($urandom); vec6 = 6'($urandom);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rdy[i] !== ((m_valid[i] == 0) || out_ready)) begin
          fails++;
          $display("FAIL rand_in_ready c=%0d dut%0d got=%b exp=%0d", c, i, rdy[i], (m_valid[i] == 0) || out_ready);
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (int'(o_valid[i]) != m_valid[i] || int'(o_idx[i]) != m_idx[i] || int'(o_zero[i]) != m_zero[i] ||
            int'(o_multi[i]) != m_multi[i] || cnt_of(i) != m_cnt[i]) begin
          fails++;
          $display("FAIL rand_out c=%0d dut%0d got v=%b i=%0d z=%b m=%b c=%0d exp v=%0d i=%0d z=%0d m=%0d c=%0d",
                   c, i, o_valid[i], o_idx[i], o_zero[i], o_multi[i], cnt_of(i),
                   m_valid[i], m_idx[i], m_zero[i], m_multi[i], m_cnt[i]);
        end
      end
    end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_multi();
    test_backpressure();
    test_zero_sat();
`ifdef ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
